// File: rtl/rst_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg: items shared by the reset sequencer.
//   - rst_seq_state_t : sequencer FSM states
//   - DEF_*           : default timing constants for the 12 MHz board clock
//   - max4()          : helper that sizes the shared phase counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET_MMCM,
    WAIT_LOCK,
    STABLE,
    REL_IC,
    RUN
  } rst_seq_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_STABLE_CYCLES   = 1024;
  localparam int unsigned DEF_STAGE_GAP       = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 120000;  // 10 ms at 12 MHz
  localparam int unsigned DEF_MMCM_RST_CYCLES = 8;
  localparam int unsigned DEF_LOSS_CNT_W      = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// -----------------------------------------------------------------------------
// rst_sequencer_if: MMCM lock input and reset/status outputs of the sequencer.
//   lock_in     : MMCM LOCKED, asynchronous to clkin
//   mmcm_rst    : MMCM RST drive, active high
//   ic_rstn     : interconnect reset, active low
//   periph_rstn : peripheral reset, active low
//   ready       : high only while running
//   lock_lost   : sticky, lock dropped after release
//   timeout_err : sticky, lock wait timed out at least once
//   loss_cnt    : saturating lock-loss count (only with RST_SEQ_LOSS_CNT_EN)
// Modports: master = sequencer side, slave = consumer/board side.
// -----------------------------------------------------------------------------
interface rst_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOSS_CNT_W = DEF_LOSS_CNT_W
) ();

  logic lock_in;
  logic mmcm_rst;
  logic ic_rstn;
  logic periph_rstn;
  logic ready;
  logic lock_lost;
  logic timeout_err;
`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  modport master (
    input  lock_in,
    output mmcm_rst, ic_rstn, periph_rstn, ready, lock_lost, timeout_err, loss_cnt
  );
  modport slave (
    output lock_in,
    input  mmcm_rst, ic_rstn, periph_rstn, ready, lock_lost, timeout_err, loss_cnt
  );
`else
  modport master (
    input  lock_in,
    output mmcm_rst, ic_rstn, periph_rstn, ready, lock_lost, timeout_err
  );
  modport slave (
    output lock_in,
    input  mmcm_rst, ic_rstn, periph_rstn, ready, lock_lost, timeout_err
  );
`endif

endinterface

// File: rtl/rst_sequencer_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff: STAGES-deep single-bit synchroniser, all flops cleared to 0 by rst.
//   clk : destination clock
//   rst : asynchronous active-high clear
//   d   : asynchronous input
//   q   : synchronised output (last stage)
// Used for MMCM lock sampling and for per-domain reset re-synchronisers.
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer: reset sequencer downstream of the clock-generation MMCM.
// Pulses the MMCM reset, waits for lock, requires lock to be stable for
// STABLE_CYCLES, then releases ic_rstn and, STAGE_GAP cycles later,
// periph_rstn/ready. Lock timeout or lock loss restarts the MMCM.
//   clkin : free-running 12 MHz board clock
//   rst   : asynchronous active-high reset
//   bus   : rst_sequencer_if.master (lock_in in, resets/status out)
// Optional feature macro: RST_SEQ_LOSS_CNT_EN adds the saturating loss_cnt.
// -----------------------------------------------------------------------------
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int unsigned LOSS_CNT_W      = DEF_LOSS_CNT_W
) (
  input logic            clkin,
  input logic            rst,
  rst_sequencer_if.master bus
);

  // One counter serves every timed phase; it tops out at (longest phase - 1).
  localparam int unsigned CNT_MAX = max4(STABLE_CYCLES, STAGE_GAP, LOCK_TIMEOUT,
                                         MMCM_RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MRC_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SC_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

  logic lock_s;

  rst_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             ic_rstn_q, ic_rstn_d;
  logic             periph_rstn_q, periph_rstn_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             timeout_err_q, timeout_err_d;
`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (bus.lock_in),
    .q   (lock_s)
  );

  // Outputs are registered from the next-state decision, so they change on
  // the same edge as the state they belong to.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mmcm_rst_d    = mmcm_rst_q;
    ic_rstn_d     = ic_rstn_q;
    periph_rstn_d = periph_rstn_q;
    ready_d       = ready_q;
    lock_lost_d   = lock_lost_q;
    timeout_err_d = timeout_err_q;
`ifdef RST_SEQ_LOSS_CNT_EN
    loss_cnt_d    = loss_cnt_q;
`endif

    unique case (state_q)
      RESET_MMCM: begin
        // lock_s is deliberately ignored while the MMCM is held in reset
        if (cnt_q == MRC_LAST) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          mmcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        // lock arrival wins over a timeout on the same edge
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LT_LAST) begin
          state_d       = RESET_MMCM;
          cnt_d         = '0;
          mmcm_rst_d    = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STABLE: begin
        // a dropout before release is a glitch: restart the lock wait quietly
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SC_LAST) begin
          state_d   = REL_IC;
          cnt_d     = '0;
          ic_rstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REL_IC, RUN: begin
        // lock loss wins over the stage-gap expiry
        if (!lock_s) begin
          state_d       = RESET_MMCM;
          cnt_d         = '0;
          mmcm_rst_d    = 1'b1;
          ic_rstn_d     = 1'b0;
          periph_rstn_d = 1'b0;
          ready_d       = 1'b0;
          lock_lost_d   = 1'b1;
`ifdef RST_SEQ_LOSS_CNT_EN
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
`endif
        end else if (state_q == REL_IC) begin
          if (cnt_q == GAP_LAST) begin
            state_d       = RUN;
            cnt_d         = '0;
            periph_rstn_d = 1'b1;
            ready_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d       = RESET_MMCM;
        cnt_d         = '0;
        mmcm_rst_d    = 1'b1;
        ic_rstn_d     = 1'b0;
        periph_rstn_d = 1'b0;
        ready_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_MMCM;
      cnt_q         <= '0;
      mmcm_rst_q    <= 1'b1;
      ic_rstn_q     <= 1'b0;
      periph_rstn_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef RST_SEQ_LOSS_CNT_EN
      loss_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mmcm_rst_q    <= mmcm_rst_d;
      ic_rstn_q     <= ic_rstn_d;
      periph_rstn_q <= periph_rstn_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
      timeout_err_q <= timeout_err_d;
`ifdef RST_SEQ_LOSS_CNT_EN
      loss_cnt_q    <= loss_cnt_d;
`endif
    end
  end

  assign bus.mmcm_rst    = mmcm_rst_q;
  assign bus.ic_rstn     = ic_rstn_q;
  assign bus.periph_rstn = periph_rstn_q;
  assign bus.ready       = ready_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.timeout_err = timeout_err_q;
`ifdef RST_SEQ_LOSS_CNT_EN
  assign bus.loss_cnt    = loss_cnt_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer: scoreboard bench for rst_sequencer.
// The stimulus process drives lock_in, steps a timeline reference model once
// per clkin edge and queues the expected output vector; a monitor process
// pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int SYNC = 2;
  localparam int SC   = 8;
  localparam int GAP  = 4;
  localparam int LT   = 50;
  localparam int MRC  = 8;
  localparam int LW   = 8;
  localparam int LMAX = (1 << LW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rst_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

  rst_sequencer #(
    .SYNC_STAGES     (SYNC),
    .STABLE_CYCLES   (SC),
    .STAGE_GAP       (GAP),
    .LOCK_TIMEOUT    (LT),
    .MMCM_RST_CYCLES (MRC),
    .LOSS_CNT_W      (LW)
  ) dut (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic          mrst;
    logic          ic;
    logic          pr;
    logic          rdy;
    logic          lost;
    logic          terr;
    logic [LW-1:0] lcnt;
  } obs_t;

  typedef struct {
    int   edge_no;
    obs_t v;
  } exp_t;

  localparam obs_t RESET_OBS = '{mrst: 1'b1, ic: 1'b0, pr: 1'b0, rdy: 1'b0,
                                 lost: 1'b0, terr: 1'b0, lcnt: '0};

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // ---------------- reference model (phase + absolute deadline) -------------
  typedef enum int {M_MRST, M_WAIT, M_STAB, M_RELIC, M_RUN} mph_t;
  mph_t m_ph;
  int   m_edge;
  int   m_deadline;
  logic m_lost;
  logic m_terr;
  int   m_loss;
  logic m_hist[$];   // lock_in samples from the last SYNC edges, oldest first

  function automatic void model_reset();
    m_ph       = M_MRST;
    m_edge     = 0;
    m_deadline = MRC;
    m_lost     = 1'b0;
    m_terr     = 1'b0;
    m_loss     = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic obs_t model_edge(input logic smp);
    logic seen;
    obs_t o;
    m_edge = m_edge + 1;
    // the decision at this edge sees the sample taken SYNC edges earlier
    seen = m_hist.pop_front();
    m_hist.push_back(smp);
    case (m_ph)
      M_MRST:  if (m_edge == m_deadline) begin m_ph = M_WAIT; m_deadline = m_edge + LT; end
      M_WAIT: begin
        if (seen) begin m_ph = M_STAB; m_deadline = m_edge + SC; end
        else if (m_edge == m_deadline) begin
          m_ph = M_MRST; m_deadline = m_edge + MRC; m_terr = 1'b1;
        end
      end
      M_STAB: begin
        if (!seen) begin m_ph = M_WAIT; m_deadline = m_edge + LT; end
        else if (m_edge == m_deadline) begin m_ph = M_RELIC; m_deadline = m_edge + GAP; end
      end
      default: begin
        if (!seen) begin
          m_ph = M_MRST; m_deadline = m_edge + MRC; m_lost = 1'b1;
          if (m_loss < LMAX) m_loss = m_loss + 1;
        end else if (m_ph == M_RELIC && m_edge == m_deadline) m_ph = M_RUN;
      end
    endcase
    o.mrst = (m_ph == M_MRST);
    o.ic   = (m_ph == M_RELIC) || (m_ph == M_RUN);
    o.pr   = (m_ph == M_RUN);
    o.rdy  = (m_ph == M_RUN);
    o.lost = m_lost;
    o.terr = m_terr;
`ifdef RST_SEQ_LOSS_CNT_EN
    o.lcnt = LW'(m_loss);
`else
    o.lcnt = '0;
`endif
    return o;
  endfunction

  // ---------------- checking helpers ----------------------------------------
  function automatic obs_t sample();
    obs_t o;
    o.mrst = bus.mmcm_rst;
    o.ic   = bus.ic_rstn;
    o.pr   = bus.periph_rstn;
    o.rdy  = bus.ready;
    o.lost = bus.lock_lost;
    o.terr = bus.timeout_err;
`ifdef RST_SEQ_LOSS_CNT_EN
    o.lcnt = bus.loss_cnt;
`else
    o.lcnt = '0;
`endif
    return o;
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // vectors print as {mrst,ic,pr,rdy,lost,terr,loss_cnt[7:0]} in hex
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
      if (n_fail >= 25) finish_run();
    end
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick(input logic nxt);
    exp_t e;
    @(posedge clk);
    #1;
    e.v       = model_edge(bus.lock_in);   // value the DUT just sampled
    e.edge_no = m_edge;
    sb_q.push_back(e);
    bus.lock_in = nxt;
  endtask

  task automatic hold(input logic val, input int n);
    for (int i = 0; i < n; i++) tick(val);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_clear", 32'(sample()), 32'(RESET_OBS));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("rst_release_state", 32'(sample()), 32'(RESET_OBS));
  endtask

  // ---------------- monitor -------------------------------------------------
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("edge%0d_outputs", e.edge_no), 32'(sample()), 32'(e.v));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus -------------------------------------------
  initial begin
    int len;
    int guard;
    int n_loss;
    bus.lock_in = 1'b0;
    apply_reset();

    // no lock: MMCM pulse, full timeout, MMCM restart, back to waiting
    hold(1'b0, 70);
    // steady lock to RUN
    hold(1'b1, 25);
    // lock loss in RUN
    hold(1'b0, 12);
    // short pulse while stable, then steady lock
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 25);

    // randomized lock waveform, mixing glitches with long segments
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(40, 70));
      else                           len = int'($urandom_range(1, 14));
      hold(1'(i % 2), len);
    end

    // repeated lock-loss cycles (long enough to saturate loss_cnt when present)
`ifdef RST_SEQ_LOSS_CNT_EN
    n_loss = LMAX + 5;
`else
    n_loss = 6;
`endif
    for (int i = 0; i < n_loss; i++) begin
      hold(1'b1, 30);
      hold(1'b0, 5);
    end
    @(negedge clk);
    #1;
`ifdef RST_SEQ_LOSS_CNT_EN
    check("loss_cnt_saturated", 32'(bus.loss_cnt), 32'(LMAX));
`endif
    check("lock_lost_sticky", 32'(bus.lock_lost), 32'd1);

    // drive into REL_IC, then reset asynchronously
    guard = 0;
    while (m_ph != M_RELIC && guard < 200) begin
      tick(1'b1);
      guard++;
    end
    check("reach_rel_ic", 32'(guard < 200), 32'd1);
    apply_reset();
    bus.lock_in = 1'b0;
    hold(1'b0, 12);
    hold(1'b1, 30);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    finish_run();
  end

endmodule
